// File: rtl/receiver_pkg.sv
// Definitions shared by the serial transmitter and receiver: frame geometry
// and FSM state encoding.
package receiver_pkg;

   localparam int unsigned TXRX_DATA_W    = 55;
   localparam int unsigned TXRX_FRAME_LEN = TXRX_DATA_W + 3;

   typedef enum logic [2:0] {
      IDLE,
      DATA,
      PARITY,
      STOP,
      WAIT_IDLE
   } rx_state_e;

endpackage

// File: rtl/receiver_if.sv
// Serial line in, received word and status flags out.
// The master modport is the receiver side; the slave modport is the line driver and consumer side.
interface receiver_if
   import receiver_pkg::*;
#(
   parameter int unsigned DATA_W = TXRX_DATA_W
);

   logic              S_Data;
   logic              RX_Ack;
   logic [DATA_W-1:0] RX_Data;
   logic              RX_Data_Valid;
   logic              RX_Error;
   logic              RX_Overrun;

   modport master (
      input  S_Data, RX_Ack,
      output RX_Data, RX_Data_Valid, RX_Error, RX_Overrun
   );

   modport slave (
      output S_Data, RX_Ack,
      input  RX_Data, RX_Data_Valid, RX_Error, RX_Overrun
   );

endinterface

// File: rtl/receiver_deser.sv
// Deserializer datapath. It holds the bit counter, the payload register and a
// running XOR over the data and parity bits.
module rx_deser #(
   parameter int unsigned DATA_W = 55,
   parameter int unsigned CNT_W  = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              shift_en,
   input  logic              par_en,
   input  logic              bit_in,
   output logic [DATA_W-1:0] data,
   output logic              last,
   output logic              par_err
);

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              acc_q, acc_d;

   always_comb begin
      cnt_d  = cnt_q;
      data_d = data_q;
      acc_d  = acc_q;
      if (clr) begin
         cnt_d = '0;
         acc_d = 1'b0;
      end
      if (shift_en) begin
         // Store each bit at the position given by cnt. The payload register is not shifted.
         for (int unsigned i = 0; i < DATA_W; i++) begin
            if (cnt_q == CNT_W'(i)) data_d[i] = bit_in;
         end
         cnt_d = cnt_q + 1'b1;
         acc_d = acc_q ^ bit_in;
      end
      if (par_en) acc_d = acc_q ^ bit_in;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         data_q <= '0;
         acc_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         data_q <= data_d;
         acc_q  <= acc_d;
      end
   end

   assign data    = data_q;
   assign last    = (cnt_q == CNT_W'(DATA_W - 1));
   assign par_err = acc_q;

endmodule

// File: rtl/receiver.sv
// Serial frame receiver: start, DATA_W bits LSB first, even parity, stop.
// The FSM and the consumer handshake live here; rx_deser holds the datapath.
module receiver
   import receiver_pkg::*;
#(
   parameter int unsigned DATA_W    = TXRX_DATA_W,
   parameter int unsigned FRAME_LEN = DATA_W + 3
) (
   input logic        Clk_S,
   input logic        Rst_n,
   receiver_if.master rx
);

   localparam int unsigned CNT_W = $clog2(FRAME_LEN);

   rx_state_e         state_q, state_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              valid_q, valid_d;
   logic              error_q, error_d;
   logic              overrun_q, overrun_d;

   logic [DATA_W-1:0] des_data;
   logic              des_last;
   logic              des_par_err;
   logic              des_clr;
   logic              des_shift;
   logic              des_par;

   assign des_clr   = (state_q == IDLE) && !rx.S_Data;
   assign des_shift = (state_q == DATA);
   assign des_par   = (state_q == PARITY);

   rx_deser #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_deser (
      .clk      (Clk_S),
      .rst_n    (Rst_n),
      .clr      (des_clr),
      .shift_en (des_shift),
      .par_en   (des_par),
      .bit_in   (rx.S_Data),
      .data     (des_data),
      .last     (des_last),
      .par_err  (des_par_err)
   );

   always_comb begin
      state_d   = state_q;
      rx_data_d = rx_data_q;
      valid_d   = valid_q;
      error_d   = 1'b0;
      overrun_d = overrun_q;

      if (valid_q && rx.RX_Ack) begin
         valid_d   = 1'b0;
         overrun_d = 1'b0;
      end

      unique case (state_q)
         IDLE:      if (!rx.S_Data) state_d = DATA;
         DATA:      if (des_last)   state_d = PARITY;
         PARITY:    state_d = STOP;
         STOP: begin
            if (!rx.S_Data) begin
               state_d = WAIT_IDLE;
               error_d = 1'b1;
            end else if (des_par_err) begin
               state_d = IDLE;
               error_d = 1'b1;
            end else begin
               state_d = IDLE;
               // A frame that completes while the consumer acks replaces the old word and is not an overrun.
               if (!valid_q || rx.RX_Ack) begin
                  rx_data_d = des_data;
                  valid_d   = 1'b1;
               end else begin
                  overrun_d = 1'b1;
               end
            end
         end
         WAIT_IDLE: if (rx.S_Data) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk_S) begin
      if (!Rst_n) begin
         state_q   <= IDLE;
         rx_data_q <= '0;
         valid_q   <= 1'b0;
         error_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rx_data_q <= rx_data_d;
         valid_q   <= valid_d;
         error_q   <= error_d;
         overrun_q <= overrun_d;
      end
   end

   assign rx.RX_Data       = rx_data_q;
   assign rx.RX_Data_Valid = valid_q;
   assign rx.RX_Error      = error_q;
   assign rx.RX_Overrun    = overrun_q;

endmodule

// File: tb/tb_receiver.sv
// Testbench for receiver. The stimulus thread queues each expected output event,
// and a negedge monitor matches the events the DUT presents against that queue.
module tb_receiver;

   localparam int unsigned DW = 55;

   typedef enum {EV_VALID, EV_ERR, EV_OVR} ev_e;
   typedef struct {
      ev_e           kind;
      logic [DW-1:0] data;
      int unsigned   cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned cyc = 0;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   exp_t        exp_q[$];

   receiver_if #(.DATA_W(DW)) rx_bus ();

   receiver #(.DATA_W(DW)) dut (
      .Clk_S (clk),
      .Rst_n (rst_n),
      .rx    (rx_bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor
   logic          prev_valid, prev_ovr;
   logic [DW-1:0] prev_data;

   task automatic check_ev(input ev_e k);
      exp_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $display("FAIL unexpected_%s: got event at cycle %0d, required none", k.name(), cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.cyc != cyc || e.data !== rx_bus.RX_Data) begin
            n_bad++;
            $display("FAIL event_%s: got %s cyc %0d data %0h, required %s cyc %0d data %0h",
                     e.kind.name(), k.name(), cyc, rx_bus.RX_Data, e.kind.name(), e.cyc, e.data);
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_bus.RX_Error) check_ev(EV_ERR);
         if (rx_bus.RX_Data_Valid && (!prev_valid || rx_bus.RX_Data !== prev_data)) check_ev(EV_VALID);
         if (rx_bus.RX_Overrun && !prev_ovr) check_ev(EV_OVR);
         if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missed_%s: got nothing by cycle %0d, required at cycle %0d",
                     exp_q[0].kind.name(), cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
         end
      end
      prev_valid = rx_bus.RX_Data_Valid;
      prev_ovr   = rx_bus.RX_Overrun;
      prev_data  = rx_bus.RX_Data;
   end

   // Stimulus
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] d, input logic par, input logic stp,
                       input logic ack_stop, input ev_e k, input logic [DW-1:0] exp_d,
                       output int unsigned st);
      tick();
      rx_bus.S_Data = 1'b0;
      st = cyc;
      exp_q.push_back('{kind: k, data: exp_d, cyc: st + 58});
      for (int i = 0; i < int'(DW); i++) begin
         tick();
         rx_bus.S_Data = d[i];
      end
      tick();
      rx_bus.S_Data = par;
      tick();
      rx_bus.S_Data = stp;
      rx_bus.RX_Ack = ack_stop;
   endtask

   initial begin
      int unsigned   st;
      logic          seen;
      logic [DW-1:0] ones;
      ones = '1;

      rx_bus.S_Data = 1'b1;
      rx_bus.RX_Ack = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_valid",   64'(rx_bus.RX_Data_Valid), 64'd0);
      chk("reset_error",   64'(rx_bus.RX_Error),      64'd0);
      chk("reset_overrun", 64'(rx_bus.RX_Overrun),    64'd0);
      chk("reset_data",    64'(rx_bus.RX_Data),       64'd0);

      // Idle line for 20 cycles
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         @(negedge clk);
         if (rx_bus.RX_Data_Valid || rx_bus.RX_Error) seen = 1'b1;
      end
      chk("idle_quiet", 64'(seen), 64'd0);

      // Good frame A5, ack at cycle 60
      send(55'h00A5, 1'b0, 1'b1, 1'b0, EV_VALID, 55'h00A5, st);
      while (cyc < st + 60) tick();
      rx_bus.RX_Ack = 1'b1;
      @(negedge clk);
      chk("valid_held_c60", 64'(rx_bus.RX_Data_Valid), 64'd1);
      tick();
      rx_bus.RX_Ack = 1'b0;
      @(negedge clk);
      chk("valid_clr_c61", 64'(rx_bus.RX_Data_Valid), 64'd0);

      // Parity error, then stop-bit error with a long low line afterwards
      send(55'h00A5, 1'b1, 1'b1, 1'b0, EV_ERR, 55'h00A5, st);
      repeat (3) tick();
      @(negedge clk);
      chk("parity_err_no_valid", 64'(rx_bus.RX_Data_Valid), 64'd0);
      send(55'h00A5, 1'b0, 1'b0, 1'b0, EV_ERR, 55'h00A5, st);
      repeat (65) tick();
      rx_bus.S_Data = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      chk("stop_err_no_valid", 64'(rx_bus.RX_Data_Valid), 64'd0);

      // Back-to-back without ack: second frame dropped
      send(55'h1, 1'b1, 1'b1, 1'b0, EV_VALID, 55'h1, st);
      send(55'h2, 1'b1, 1'b1, 1'b0, EV_OVR,   55'h1, st);
      repeat (5) tick();
      @(negedge clk);
      chk("ovr_data_kept", 64'(rx_bus.RX_Data),       64'h1);
      chk("ovr_sticky",    64'(rx_bus.RX_Overrun),    64'd1);
      chk("ovr_valid",     64'(rx_bus.RX_Data_Valid), 64'd1);
      tick();
      rx_bus.RX_Ack = 1'b1;
      tick();
      rx_bus.RX_Ack = 1'b0;
      @(negedge clk);
      chk("ovr_cleared", 64'(rx_bus.RX_Overrun),    64'd0);
      chk("ack_clr",     64'(rx_bus.RX_Data_Valid), 64'd0);

      // Ack in the same cycle a new frame completes
      send(55'h1, 1'b1, 1'b1, 1'b0, EV_VALID, 55'h1, st);
      send(55'h2, 1'b1, 1'b1, 1'b1, EV_VALID, 55'h2, st);
      tick();
      rx_bus.RX_Ack = 1'b0;
      @(negedge clk);
      chk("same_ack_no_ovr", 64'(rx_bus.RX_Overrun),    64'd0);
      chk("same_ack_valid",  64'(rx_bus.RX_Data_Valid), 64'd1);
      chk("same_ack_data",   64'(rx_bus.RX_Data),       64'h2);

      // Reset during data bit 20, then a full all-ones frame
      tick();
      rx_bus.S_Data = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         rx_bus.S_Data = 1'b1;
      end
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      rx_bus.S_Data = 1'b1;
      @(negedge clk);
      chk("midrst_valid",   64'(rx_bus.RX_Data_Valid), 64'd0);
      chk("midrst_data",    64'(rx_bus.RX_Data),       64'd0);
      chk("midrst_error",   64'(rx_bus.RX_Error),      64'd0);
      chk("midrst_overrun", 64'(rx_bus.RX_Overrun),    64'd0);
      repeat (2) tick();
      send(ones, 1'b1, 1'b1, 1'b0, EV_VALID, ones, st);
      repeat (5) tick();
      @(negedge clk);
      chk("ones_data", 64'(rx_bus.RX_Data), 64'(ones));
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
